// File: rtl/sram_pkg.sv
// Types and constants shared by the SRAM reader and the board-test writer.
package sram_pkg;

    localparam int SRAM_ADDR_W = 15;
    localparam int SRAM_DATA_W = 8;

    typedef logic [SRAM_ADDR_W-1:0] sram_addr_t;
    typedef logic [SRAM_DATA_W-1:0] sram_data_t;

    typedef enum logic [2:0] {
        RD_IDLE   = 3'd0,
        RD_SETUP  = 3'd1,
        RD_ACCESS = 3'd2,
        RD_VALID  = 3'd3,
        RD_DONE   = 3'd4
    } reader_state_t;

    // The address space is 2^15 bytes, so bursts wrap 0x7FFF -> 0x0000.
    function automatic sram_addr_t addr_next(input sram_addr_t a);
        return a + sram_addr_t'(1);
    endfunction

endpackage

// File: rtl/sram_reader.sv
// Burst reader for an asynchronous SRAM behind address/data transceivers.
// Each byte: one SETUP cycle, WAIT_CYCLES of ACCESS, then VALID until the consumer takes it.
module sram_reader
    import sram_pkg::*;
#(
    parameter int WAIT_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [SRAM_ADDR_W-1:0] base_addr,
    input  logic [SRAM_ADDR_W-1:0] length,
    output logic                   busy,
    output logic                   done,
    output logic [SRAM_DATA_W-1:0] rd_data,
    output logic [SRAM_ADDR_W-1:0] rd_addr,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [SRAM_ADDR_W-1:0] addr,
    input  logic [SRAM_DATA_W-1:0] data_in,
    output logic                   n_ce,
    output logic                   n_oe,
    output logic                   n_write,
    output logic                   t_r_data,
    output logic                   t_r_addr,
    output logic                   n_oe_trans,
    output reader_state_t          state
);

    // Handshake: a byte transfers on every rising edge where rd_valid and rd_ready
    // are both high; once raised, rd_valid stays high and rd_data/rd_addr stay fixed
    // until that edge.

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    reader_state_t state_next;
    sram_addr_t    cur_addr;
    sram_addr_t    remaining;
    logic [3:0]    wait_cnt;
    logic          load;
    logic          advance;
    logic          capture;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RD_IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            wait_cnt  <= '0;
            rd_data   <= '0;
            rd_addr   <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                cur_addr  <= base_addr;
                remaining <= length;
            end else if (advance) begin
                cur_addr  <= addr_next(cur_addr);
                remaining <= remaining - sram_addr_t'(1);
            end
            if (state == RD_ACCESS && !capture) begin
                wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt <= '0;
            end
            if (capture) begin
                rd_data <= data_in;
                rd_addr <= cur_addr;
            end
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        advance    = 1'b0;
        capture    = 1'b0;
        case (state)
            RD_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RD_SETUP;
                end
            end
            RD_SETUP: begin
                state_next = RD_ACCESS;
            end
            RD_ACCESS: begin
                // Data is sampled on the edge that closes the last wait cycle.
                if (wait_cnt == WAIT_LAST) begin
                    capture    = 1'b1;
                    state_next = RD_VALID;
                end
            end
            RD_VALID: begin
                if (rd_ready) begin
                    if (remaining == '0) begin
                        state_next = RD_DONE;
                    end else begin
                        advance    = 1'b1;
                        state_next = RD_SETUP;
                    end
                end
            end
            RD_DONE: begin
                state_next = RD_IDLE;
            end
            default: begin
                state_next = RD_IDLE;
            end
        endcase
    end

    always_comb begin
        busy       = (state != RD_IDLE);
        done       = (state == RD_DONE);
        rd_valid   = (state == RD_VALID);
        addr       = cur_addr;
        n_ce       = 1'b1;
        n_oe       = 1'b1;
        n_oe_trans = 1'b1;
        n_write    = 1'b1;
        t_r_data   = 1'b0;
        t_r_addr   = 1'b1;
        // The transceivers open before the SRAM drives and close only after it stops.
        if (state == RD_SETUP || state == RD_ACCESS || state == RD_VALID) begin
            n_ce       = 1'b0;
            n_oe_trans = 1'b0;
        end
        if (state == RD_ACCESS) begin
            n_oe = 1'b0;
        end
    end

endmodule

// File: tb/tb_sram_reader.sv
// Self-checking bench for sram_reader: SRAM model, scoreboard of expected (addr, data)
// pairs built from the burst request, and one task per scenario.
`timescale 1ns/1ps
module tb_sram_reader;
    import sram_pkg::*;

    localparam int W          = 3;
    localparam int CYC_BUDGET = 2000;
    localparam logic [46:0] RESET_VEC = {3'b000, 8'h00, 15'h0000, 15'h0000, 6'b111101};

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          rd_ready = 1'b0;
    logic [14:0]   base_addr = '0;
    logic [14:0]   length = '0;
    logic          busy, done, rd_valid;
    logic          n_ce, n_oe, n_write, t_r_data, t_r_addr, n_oe_trans;
    logic [7:0]    rd_data, data_in;
    logic [14:0]   rd_addr, addr;
    reader_state_t state;

    int          checks = 0;
    int          errors = 0;
    logic [22:0] exp_q[$];
    logic [22:0] got_q[$];
    int          xfer_cyc[$];
    int          cyc = 0;
    int          done_cnt = 0;
    logic        expect_done = 1'b0;

    always #5 clk = ~clk;

    sram_reader #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .length(length), .busy(busy), .done(done), .rd_data(rd_data),
        .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_ready(rd_ready), .addr(addr),
        .data_in(data_in), .n_ce(n_ce), .n_oe(n_oe), .n_write(n_write),
        .t_r_data(t_r_data), .t_r_addr(t_r_addr), .n_oe_trans(n_oe_trans),
        .state(state)
    );

    function automatic logic [7:0] mem_byte(input logic [14:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    // SRAM drives the bus only while both selected for output.
    assign data_in = (!n_oe && !n_ce) ? mem_byte(addr) : 8'hxx;

    // Bus-rule monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        logic [22:0] e;
        cyc++;
        checks++;
        if (n_write !== 1'b1 || t_r_data !== 1'b0 || t_r_addr !== 1'b1) begin
            errors++;
            $display("FAIL bus_dir: n_write=%b t_r_data=%b t_r_addr=%b, required 1 0 1",
                     n_write, t_r_data, t_r_addr);
        end
        checks++;
        if (n_oe === 1'b0 && (n_oe_trans !== 1'b0 || n_ce !== 1'b0)) begin
            errors++;
            $display("FAIL oe_gating: n_oe=0 with n_oe_trans=%b n_ce=%b, required 0 0",
                     n_oe_trans, n_ce);
        end
        checks++;
        if (done !== expect_done) begin
            errors++;
            $display("FAIL done_pulse: done=%b required %b at cycle %0d", done, expect_done, cyc);
        end
        expect_done = 1'b0;
        if (done === 1'b1) done_cnt++;
        if (rd_valid === 1'b1) begin
            checks++;
            if (addr !== rd_addr) begin
                errors++;
                $display("FAIL addr_hold: addr=%h required %h", addr, rd_addr);
            end
        end
        if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
            checks++;
            if ($isunknown({rd_addr, rd_data})) begin
                errors++;
                $display("FAIL x_capture: rd_addr=%h rd_data=%h", rd_addr, rd_data);
            end
            got_q.push_back({rd_addr, rd_data});
            xfer_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_xfer: addr=%h data=%h, no byte outstanding", rd_addr, rd_data);
            end else begin
                e = exp_q.pop_front();
                if ({rd_addr, rd_data} !== e) begin
                    errors++;
                    $display("FAIL xfer: addr=%h data=%h required addr=%h data=%h",
                             rd_addr, rd_data, e[22:8], e[7:0]);
                end
                if (exp_q.size() == 0) expect_done = 1'b1;
            end
        end
    end

    task automatic push_expected(input logic [14:0] b, input logic [14:0] len);
        for (int i = 0; i <= int'(len); i++) begin
            logic [14:0] a;
            a = b + 15'(i);
            exp_q.push_back({a, mem_byte(a)});
        end
    endtask

    // Returns one tick after the edge that samples start.
    task automatic start_burst(input logic [14:0] b, input logic [14:0] len);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = b;
        length = len;
        push_expected(b, len);
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = 15'($urandom);
        length = 15'($urandom);
    endtask

    task automatic run_until_idle(input bit rand_ready, input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            if (rand_ready) rd_ready = 1'($urandom_range(0, 1));
            @(negedge clk); #1;
            n++;
        end while ((busy !== 1'b0 || exp_q.size() != 0) && n < CYC_BUDGET);
        rd_ready = 1'b1;
        checks++;
        if (n >= CYC_BUDGET) begin
            errors++;
            $display("FAIL %s_timeout: busy=%b outstanding=%0d after %0d cycles",
                     name, busy, exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (rd_valid !== 1'b1 && n < CYC_BUDGET);
        checks++;
        if (n >= CYC_BUDGET) begin
            errors++;
            $display("FAIL %s_valid_timeout: rd_valid=%b required 1", name, rd_valid);
        end
    endtask

    task automatic test_reset();
        int d0;
        reset_n = 1'b0;
        rd_ready = 1'b1;
        #23;
        checks++;
        if ({busy, done, rd_valid, rd_data, rd_addr, addr, n_ce, n_oe, n_write,
             n_oe_trans, t_r_data, t_r_addr} !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_values: got %h required %h",
                     {busy, done, rd_valid, rd_data, rd_addr, addr, n_ce, n_oe, n_write,
                      n_oe_trans, t_r_data, t_r_addr}, RESET_VEC);
        end
        checks++;
        if (state !== RD_IDLE) begin
            errors++;
            $display("FAIL reset_state: state=%0d required %0d", state, RD_IDLE);
        end
        d0 = done_cnt;
        got_q.delete();
        // Release and request on the very next rising edge.
        @(posedge clk); #1;
        reset_n = 1'b1;
        start = 1'b1;
        base_addr = 15'h0100;
        length = 15'd0;
        push_expected(15'h0100, 15'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL first_start: busy=%b required 1", busy);
        end
        run_until_idle(1'b0, "first_start");
        checks++;
        if (got_q.size() != 1 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL first_start_count: bytes=%0d dones=%0d required 1 1",
                     got_q.size(), done_cnt - d0);
        end
    endtask

    task automatic test_basic();
        logic [22:0] basic_exp [4];
        int d0, base_cyc;
        basic_exp[0] = {15'h0010, 8'h4A};
        basic_exp[1] = {15'h0011, 8'h4B};
        basic_exp[2] = {15'h0012, 8'h48};
        basic_exp[3] = {15'h0013, 8'h49};
        d0 = done_cnt;
        got_q.delete();
        xfer_cyc.delete();
        rd_ready = 1'b1;
        start_burst(15'h0010, 15'd3);
        base_cyc = cyc;
        run_until_idle(1'b0, "basic");
        checks++;
        if (got_q.size() != 4) begin
            errors++;
            $display("FAIL basic_count: bytes=%0d required 4", got_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_q[i] !== basic_exp[i]) begin
                    errors++;
                    $display("FAIL basic_byte%0d: got %h required %h", i, got_q[i], basic_exp[i]);
                end
                checks++;
                if (xfer_cyc[i] - base_cyc != 2 + W + i * (W + 2)) begin
                    errors++;
                    $display("FAIL basic_timing%0d: cycle %0d required %0d", i,
                             xfer_cyc[i] - base_cyc, 2 + W + i * (W + 2));
                end
            end
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL basic_done: dones=%0d required 1", done_cnt - d0);
        end
    endtask

    task automatic test_wrap();
        logic [14:0] wrap_exp [3];
        wrap_exp[0] = 15'h7FFE;
        wrap_exp[1] = 15'h7FFF;
        wrap_exp[2] = 15'h0000;
        got_q.delete();
        rd_ready = 1'b1;
        start_burst(15'h7FFE, 15'd2);
        run_until_idle(1'b0, "wrap");
        checks++;
        if (got_q.size() != 3) begin
            errors++;
            $display("FAIL wrap_count: bytes=%0d required 3", got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_q[i][22:8] !== wrap_exp[i]) begin
                    errors++;
                    $display("FAIL wrap_addr%0d: got %h required %h", i, got_q[i][22:8], wrap_exp[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [14:0] b, a1;
        int n, d0;
        b = 15'($urandom);
        a1 = b + 15'd1;
        d0 = done_cnt;
        got_q.delete();
        rd_ready = 1'b1;
        start_burst(b, 15'd3);
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (got_q.size() == 0 && n < CYC_BUDGET);
        @(posedge clk); #1;
        rd_ready = 1'b0;
        wait_valid("bp");
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rd_valid !== 1'b1 || n_oe !== 1'b1 || rd_data !== mem_byte(a1) ||
                rd_addr !== a1 || addr !== a1) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b n_oe=%b data=%h rd_addr=%h addr=%h required 1 1 %h %h %h",
                         i, rd_valid, n_oe, rd_data, rd_addr, addr, mem_byte(a1), a1, a1);
            end
            if (i < 9) begin
                @(negedge clk); #1;
            end
        end
        @(posedge clk); #1;
        rd_ready = 1'b1;
        run_until_idle(1'b0, "bp");
        checks++;
        if (got_q.size() != 4 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL bp_count: bytes=%0d dones=%0d required 4 1", got_q.size(), done_cnt - d0);
        end
    endtask

    task automatic test_start_ignored();
        logic [14:0] b;
        b = 15'($urandom);
        got_q.delete();
        rd_ready = 1'b0;
        start_burst(b, 15'd2);
        wait_valid("ign");
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = b ^ 15'h4000;
        length = 15'd7;
        @(posedge clk); #1;
        start = 1'b0;
        rd_ready = 1'b1;
        run_until_idle(1'b0, "ign");
        checks++;
        if (got_q.size() != 3) begin
            errors++;
            $display("FAIL ign_count: bytes=%0d required 3", got_q.size());
        end
        repeat (4) begin
            @(negedge clk); #1;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ign_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset_mid_access();
        logic [14:0] b;
        int n;
        b = 15'($urandom);
        got_q.delete();
        rd_ready = 1'b1;
        start_burst(b, 15'd4);
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (got_q.size() == 0 && n < CYC_BUDGET);
        do begin
            @(negedge clk); #1;
            n++;
        end while (n_oe !== 1'b0 && n < CYC_BUDGET);
        checks++;
        if (n >= CYC_BUDGET) begin
            errors++;
            $display("FAIL mid_reset_access_timeout: n_oe=%b required 0", n_oe);
        end
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        expect_done = 1'b0;
        #1;
        checks++;
        if ({busy, done, rd_valid, rd_data, rd_addr, addr, n_ce, n_oe, n_write,
             n_oe_trans, t_r_data, t_r_addr} !== RESET_VEC) begin
            errors++;
            $display("FAIL mid_reset_values: got %h required %h",
                     {busy, done, rd_valid, rd_data, rd_addr, addr, n_ce, n_oe, n_write,
                      n_oe_trans, t_r_data, t_r_addr}, RESET_VEC);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        b = 15'($urandom);
        got_q.delete();
        start_burst(b, 15'($urandom_range(0, 3)));
        run_until_idle(1'b0, "post_reset");
        checks++;
        if (got_q.size() == 0 || got_q[0][22:8] !== b) begin
            errors++;
            $display("FAIL post_reset_base: first addr=%h required %h",
                     (got_q.size() == 0) ? 15'h0 : got_q[0][22:8], b);
        end
    endtask

    task automatic test_random();
        logic [14:0] b, len;
        int d0;
        for (int t = 0; t < 8; t++) begin
            b = ($urandom_range(0, 2) == 0) ? 15'h7FFC + 15'($urandom_range(0, 3)) : 15'($urandom);
            len = 15'($urandom_range(0, 6));
            d0 = done_cnt;
            got_q.delete();
            start_burst(b, len);
            run_until_idle(1'b1, "random");
            checks++;
            if (got_q.size() != int'(len) + 1 || done_cnt - d0 != 1) begin
                errors++;
                $display("FAIL random%0d_count: bytes=%0d dones=%0d required %0d 1",
                         t, got_q.size(), done_cnt - d0, int'(len) + 1);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_start_ignored();
        test_reset_mid_access();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_reader.md
SRAM_READER -- requirements
Module: sram_reader

Interface
REQ-001 Parameter: WAIT_CYCLES, 3, number of clk cycles n_oe is held low before data is sampled (range 1..15).
REQ-002 clk  in  1  sole clock; all logic on its rising edge.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  burst request; sampled only in IDLE.
REQ-005 base_addr  in  15  first SRAM address of the burst, captured on start.
REQ-006 length  in  15  burst length minus one (0 means 1 byte, 0x7FFF means 32768 bytes), captured on start.
REQ-007 busy  out  1  high in every state except IDLE.
REQ-008 done  out  1  one-cycle pulse after the last byte transfers.
REQ-009 rd_data  out  8  byte read from the SRAM.
REQ-010 rd_addr  out  15  address that rd_data was read from.
REQ-011 rd_valid  out  1  rd_data/rd_addr valid.
REQ-012 rd_ready  in  1  consumer accepts; a transfer occurs on a cycle with rd_valid and rd_ready both high.
REQ-013 addr  out  15  SRAM address bus (through the address transceiver).
REQ-014 data_in  in  8  SRAM data bus as received through the data transceiver.
REQ-015 n_ce, n_oe, n_write  out  1 each  SRAM chip enable, output enable, write enable (all active-low).
REQ-016 t_r_data, t_r_addr, n_oe_trans  out  1 each  data transceiver direction (1 = transmit), address transceiver direction, transceiver enable (active-low).

Function
REQ-017 States: IDLE, SETUP, ACCESS, VALID, DONE.
REQ-018 IDLE: start=1 captures base_addr into the current address and length into the remaining count, then goes to SETUP; otherwise stays in IDLE.
REQ-019 SETUP lasts 1 cycle: addr = current address, n_ce=0, n_oe=1; next state ACCESS.
REQ-020 ACCESS lasts exactly WAIT_CYCLES cycles with n_ce=0 and n_oe=0; data_in is registered into rd_data on the clock edge that ends the last ACCESS cycle; next state VALID.
REQ-021 VALID: rd_valid=1, n_oe=1, n_ce=0, addr held, rd_data and rd_addr stable until the transfer.
REQ-022 VALID with a transfer and remaining count=0: go to DONE; with a transfer and remaining count>0: increment the address, decrement the count, go to SETUP; without a transfer: stay in VALID.
REQ-023 DONE lasts 1 cycle: done=1, n_ce=1; next state IDLE.
REQ-024 Latency: if start is sampled at edge E0, the first rd_valid appears in cycle 2+WAIT_CYCLES after E0; with rd_ready held high, throughput is one byte per WAIT_CYCLES+2 cycles.
REQ-025 Address arithmetic is modulo 2^15: 0x7FFF increments to 0x0000 inside a burst.
REQ-026 start while busy is ignored and does not alter the captured address or count.
REQ-027 n_write=1, t_r_data=0 and t_r_addr=1 in every state; the module never writes the SRAM.
REQ-028 n_oe_trans=0 in SETUP, ACCESS and VALID, and 1 in IDLE and DONE.
REQ-029 n_oe is low only in ACCESS, so the SRAM never drives the bus while the transceivers are disabled.

Reset
REQ-030 reset_n low forces IDLE immediately, independent of clk, from any state including mid-ACCESS.
REQ-031 Reset values: busy=0, done=0, rd_valid=0, rd_data=0, rd_addr=0, addr=0, n_ce=1, n_oe=1, n_write=1, n_oe_trans=1, t_r_data=0, t_r_addr=1, internal count and wait counter 0.
REQ-032 After reset_n deasserts, the first start is honoured on the first rising edge.

Structure
REQ-033 Shared package sram_pkg holds SRAM_ADDR_W=15, SRAM_DATA_W=8 and the reader state encoding; the board-test writer uses the same package.
REQ-034 No sub-module: the wait counter (4 bits) and the burst counter (15 bits) are inline.

Verification
REQ-035 SRAM model preloaded with mem[a]=a[7:0]^0x5A; start with base 0x0010, length 3, rd_ready=1 -> four transfers with (addr,data) = (0x10,0x4A), (0x11,0x4B), (0x12,0x48), (0x13,0x49), then one done pulse; first rd_valid in cycle 5 after the start edge.
REQ-036 Wrap: base 0x7FFE, length 2 -> transfers at addresses 0x7FFE, 0x7FFF, 0x0000.
REQ-037 Backpressure: rd_ready low for 10 cycles on the second byte -> rd_valid, rd_data and addr held, n_oe=1 throughout, no byte lost or duplicated.
REQ-038 Model drives X except while n_oe=0 && n_ce=0 -> no X ever captured; assertion fails if n_oe=0 while n_oe_trans=1, or if n_write=0 at any time.
REQ-039 reset_n pulsed low during ACCESS of byte 2 of a 5-byte burst -> all outputs take their REQ-031 values asynchronously; a new start then reads correctly from its own base_addr.
REQ-040 start pulsed during VALID with a different base_addr -> ignored; the burst completes with its original addresses.
